regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file (x0 hardwired to zero).
- Shares that port between the in-order pipeline WB stage and the multi-cycle MUL/DIV unit (MDU).
- Keeps a scoreboard of registers with MDU results outstanding, so decode can stall on RAW/WAW hazards.
- Sits between the WB stage, the MDU and the register-file write inputs, and feeds a stall signal to the hazard logic.

Parameters:
- STARVE_LIMIT, 4: consecutive blocked MDU cycles before the pipeline is forced to yield (1..2^CNT_W-1).
- CNT_W, 3: width of the starvation counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous reset, active-low
- pipe_wb_en  in  1  pipeline WB write request
- pipe_rd  in  5  pipeline destination register
- pipe_data  in  32  pipeline write data
- pipe_hold  out  1  registered; WB stage must freeze and re-present its write next cycle
- mdu_valid  in  1  MDU result valid
- mdu_rd  in  5  MDU destination register
- mdu_data  in  32  MDU result
- mdu_ready  out  1  MDU result accepted this cycle
- issue_en  in  1  decode issued an MDU op this cycle
- issue_rd  in  5  destination of the issued MDU op
- id_rs1  in  5  decode source 1
- id_rs2  in  5  decode source 2
- id_rd  in  5  decode destination
- id_stall  out  1  hazard against an outstanding MDU result
- wb_en  out  1  register-file write enable
- rd_index  out  5  register-file write index
- wb_data  out  32  register-file write data
- sb_err  out  1  sticky; MDU op issued to an already-pending register

Behaviour:
- Reset (rst_n low, async): state=IDLE, starvation counter=0, pending=0, pipe_hold=0, sb_err=0.
  - Grant logic gives wb_en=0 and mdu_ready=0 while reset is asserted.
- Effective requests: pipe_req = pipe_wb_en & (pipe_rd!=0).
  - An MDU result targeting x0 is accepted (mdu_ready=1), never written (wb_en=0 from MDU), and clears nothing.
- Grant is combinational, zero latency; the register file captures the write on the same edge.
  - IDLE/WAIT: pipe_req wins. MDU is granted only when pipe_req=0.
  - FORCE: MDU is granted; pipeline is ignored (pipe_hold=1 this cycle).
  - Granted source drives rd_index and wb_data. wb_en=1 if a grant exists with rd!=0.
  - With no grant: wb_en=0, rd_index=0, wb_data=0.
- mdu_ready = mdu_valid & MDU granted. MDU must hold rd and data stable until ready.
- FSM:
  - IDLE -> WAIT: mdu_valid & pipe_req (MDU blocked). Counter loads 1.
  - WAIT -> IDLE: MDU granted.
  - WAIT, still blocked: counter++. When counter==STARVE_LIMIT, go to FORCE and set pipe_hold=1.
  - FORCE -> IDLE: always next cycle. pipe_hold=0, counter=0. The MDU is granted in FORCE by construction.
  - mdu_valid dropping in WAIT is illegal. The block returns to IDLE and the counter clears.
- Scoreboard, 32-bit pending vector; bit 0 is never set.
  - Set: issue_en & issue_rd!=0 sets pending[issue_rd].
  - Clear: an accepted MDU write clears pending[mdu_rd].
  - Same-cycle set and clear of the same index: set wins (a new op has been issued).
  - issue_en to an already-pending register (without same-cycle clear) sets sb_err until reset.
- id_stall (combinational) = (pending[id_rs1] & id_rs1!=0) | (pending[id_rs2] & id_rs2!=0) | (pending[id_rd] & id_rd!=0).
  - In the cycle a pending register is being written, stall stays 1. It drops the next cycle, once the register file holds the value.
- Reset mid-operation drops all pending entries and any in-flight grant; the MDU must be reset together with the block.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> wb_en=0, pipe_hold=0, id_stall=0, sb_err=0, rd_index=0.
- Pipe only: pipe_wb_en=1, pipe_rd=5, pipe_data=0x1234 -> same cycle wb_en=1, rd_index=5, wb_data=0x1234.
- Collision: pipe_req every cycle (rd=3), MDU valid rd=7 data=0xBEEF, STARVE_LIMIT=4 -> blocked 4 cycles, then one FORCE cycle.
  - FORCE cycle: pipe_hold=1, wb_en=1, rd_index=7, mdu_ready=1.
  - Next cycle: pipeline write to x3 resumes.
- Scoreboard: issue_rd=9 -> id_rs1=9 gives id_stall=1 until the MDU write to x9 is accepted; id_stall=0 the cycle after.
- Same-cycle clear and set: MDU writes x9 while issue_en, issue_rd=9 -> pending[9] stays 1, sb_err=0.
- x0 and errors: issue_rd=0 -> no stall on id_rs1=0, and an MDU result to x0 gives mdu_ready=1, wb_en=0. Issuing x4 twice without a clear -> sb_err=1 until reset.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Signal bundle between the WB stage, the MUL/DIV unit, decode and the
// register-file write port.
interface regfile_wb_arbiter_if;
  // Handshakes:
  // - mdu_valid/mdu_ready: a result transfers on a cycle where both are high.
  //   The MDU holds mdu_rd/mdu_data stable and keeps mdu_valid high until
  //   mdu_ready.
  // - pipe_wb_en: the write is taken when pipe_hold is low. When pipe_hold is
  //   high, the WB stage re-presents the same write on the next cycle.
  logic        pipe_wb_en;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_hold;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_stall;
  logic        wb_en;
  logic [4:0]  rd_index;
  logic [31:0] wb_data;
  logic        sb_err;

  modport slave (
    input  pipe_wb_en, pipe_rd, pipe_data, mdu_valid, mdu_rd, mdu_data,
           issue_en, issue_rd, id_rs1, id_rs2, id_rd,
    output pipe_hold, mdu_ready, id_stall, wb_en, rd_index, wb_data, sb_err
  );

  modport master (
    output pipe_wb_en, pipe_rd, pipe_data, mdu_valid, mdu_rd, mdu_data,
           issue_en, issue_rd, id_rs1, id_rs2, id_rd,
    input  pipe_hold, mdu_ready, id_stall, wb_en, rd_index, wb_data, sb_err
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between the WB stage and the MDU, with
// starvation protection and a pending-result scoreboard for decode hazards.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_wb_arbiter_if.slave   bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               hold_q;
  logic [31:0]        pend_q, pend_d, set_mask, clr_mask;
  logic               err_q, err_d;
  logic               pipe_req, pipe_gnt, mdu_gnt;

  // Grant is gated by rst_n so nothing reaches the register file during reset.
  always_comb begin
    pipe_req = bus.pipe_wb_en & (bus.pipe_rd != 5'd0);
    pipe_gnt = 1'b0;
    mdu_gnt  = 1'b0;
    if (rst_n) begin
      if (state_q == FORCE) begin
        mdu_gnt = bus.mdu_valid;
      end else begin
        pipe_gnt = pipe_req;
        mdu_gnt  = bus.mdu_valid & ~pipe_req;
      end
    end
  end

  always_comb begin
    bus.wb_en    = 1'b0;
    bus.rd_index = 5'd0;
    bus.wb_data  = 32'd0;
    if (pipe_gnt) begin
      bus.wb_en    = 1'b1;
      bus.rd_index = bus.pipe_rd;
      bus.wb_data  = bus.pipe_data;
    end else if (mdu_gnt) begin
      bus.wb_en    = (bus.mdu_rd != 5'd0);
      bus.rd_index = bus.mdu_rd;
      bus.wb_data  = bus.mdu_data;
    end
  end

  assign bus.mdu_ready = mdu_gnt;
  assign bus.pipe_hold = hold_q;
  assign bus.sb_err    = err_q;
  assign dbg_state     = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.mdu_valid & pipe_req) begin
          cnt_d   = CNT_W'(1);
          state_d = (STARVE_LIMIT == 1) ? FORCE : WAIT;
        end
      end
      WAIT: begin
        // A dropped mdu_valid here is a protocol violation; recover to IDLE.
        if (!bus.mdu_valid || mdu_gnt) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(STARVE_LIMIT)) state_d = FORCE;
        end
      end
      FORCE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A new issue to the index being retired this cycle keeps the bit set.
  always_comb begin
    set_mask = (bus.issue_en && bus.issue_rd != 5'd0) ? (32'd1 << bus.issue_rd) : 32'd0;
    clr_mask = (mdu_gnt && bus.mdu_rd != 5'd0) ? (32'd1 << bus.mdu_rd) : 32'd0;
    pend_d   = (pend_q & ~clr_mask) | set_mask;
    err_d    = err_q | (|(set_mask & pend_q & ~clr_mask));
  end

  assign bus.id_stall = (pend_q[bus.id_rs1] & (bus.id_rs1 != 5'd0)) |
                        (pend_q[bus.id_rs2] & (bus.id_rs2 != 5'd0)) |
                        (pend_q[bus.id_rd]  & (bus.id_rd  != 5'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= 1'b0;
      pend_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= (state_d == FORCE);
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: hand-computed vector table, reset sequences
// and a randomized run against a rule-level reference model.
module tb_regfile_wb_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int CNT_W        = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pe;   logic [4:0] prd; logic [31:0] pdata;
    logic        mv;   logic [4:0] mrd; logic [31:0] mdata;
    logic        ie;   logic [4:0] ird;
    logic [4:0]  rs1;  logic [4:0] rs2; logic [4:0]  rdd;
    logic        e_wb; logic [4:0] e_idx; logic [31:0] e_data;
    logic        e_rdy; logic e_hold; logic e_stall; logic e_err;
  } vec_t;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [36:0] exp_q[$];
  vec_t tbl[$];

  // Reference model state: set of outstanding registers, sticky error,
  // length of the current run of blocked MDU cycles, forced-yield flag.
  bit m_pend[32];
  bit m_err;
  int m_streak;
  bit m_force;

  function automatic vec_t row(
    input logic pe, input logic [4:0] prd, input logic [31:0] pdata,
    input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
    input logic ie, input logic [4:0] ird,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rdd,
    input logic e_wb, input logic [4:0] e_idx, input logic [31:0] e_data,
    input logic e_rdy, input logic e_hold, input logic e_stall, input logic e_err);
    vec_t v;
    v.pe = pe; v.prd = prd; v.pdata = pdata;
    v.mv = mv; v.mrd = mrd; v.mdata = mdata;
    v.ie = ie; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2; v.rdd = rdd;
    v.e_wb = e_wb; v.e_idx = e_idx; v.e_data = e_data;
    v.e_rdy = e_rdy; v.e_hold = e_hold; v.e_stall = e_stall; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    bus.pipe_wb_en = v.pe;  bus.pipe_rd = v.prd;  bus.pipe_data = v.pdata;
    bus.mdu_valid  = v.mv;  bus.mdu_rd  = v.mrd;  bus.mdu_data  = v.mdata;
    bus.issue_en   = v.ie;  bus.issue_rd = v.ird;
    bus.id_rs1 = v.rs1; bus.id_rs2 = v.rs2; bus.id_rd = v.rdd;
  endtask

  task automatic compare(input vec_t v, input string tag, input int idx);
    check($sformatf("%s[%0d].wb_en", tag, idx),     37'(bus.wb_en),     37'(v.e_wb));
    check($sformatf("%s[%0d].rd_index", tag, idx),  37'(bus.rd_index),  37'(v.e_idx));
    check($sformatf("%s[%0d].wb_data", tag, idx),   37'(bus.wb_data),   37'(v.e_data));
    check($sformatf("%s[%0d].mdu_ready", tag, idx), 37'(bus.mdu_ready), 37'(v.e_rdy));
    check($sformatf("%s[%0d].pipe_hold", tag, idx), 37'(bus.pipe_hold), 37'(v.e_hold));
    check($sformatf("%s[%0d].id_stall", tag, idx),  37'(bus.id_stall),  37'(v.e_stall));
    check($sformatf("%s[%0d].sb_err", tag, idx),    37'(bus.sb_err),    37'(v.e_err));
    if (v.e_wb) exp_q.push_back({v.e_idx, v.e_data});
    if (bus.wb_en === 1'b1) begin
      if (exp_q.size() == 0) check($sformatf("%s[%0d].unexpected_write", tag, idx), {bus.rd_index, bus.wb_data}, 37'd0);
      else check($sformatf("%s[%0d].write_stream", tag, idx), {bus.rd_index, bus.wb_data}, exp_q.pop_front());
    end
  endtask

  task automatic cycle(input vec_t v, input string tag, input int idx);
    drive(v);
    @(negedge clk);
    compare(v, tag, idx);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_err = 1'b0; m_streak = 0; m_force = 1'b0;
  endtask

  // Expected outputs from the arbitration and scoreboard rules, then advance.
  task automatic model_step(inout vec_t v);
    bit req, pg, mg, clr_hit, set_hit;
    req = v.pe && (v.prd != 0);
    pg = 0; mg = 0;
    if (m_force) mg = v.mv;
    else begin pg = req; mg = v.mv && !req; end
    v.e_rdy = mg; v.e_hold = m_force; v.e_err = m_err;
    v.e_wb = 0; v.e_idx = 0; v.e_data = 0;
    if (pg) begin v.e_wb = 1; v.e_idx = v.prd; v.e_data = v.pdata; end
    else if (mg) begin v.e_wb = (v.mrd != 0); v.e_idx = v.mrd; v.e_data = v.mdata; end
    v.e_stall = (m_pend[v.rs1] && v.rs1 != 0) || (m_pend[v.rs2] && v.rs2 != 0) ||
                (m_pend[v.rdd] && v.rdd != 0);
    clr_hit = mg && (v.mrd != 0);
    set_hit = v.ie && (v.ird != 0);
    if (set_hit && m_pend[v.ird] && !(clr_hit && v.mrd == v.ird)) m_err = 1;
    if (clr_hit) m_pend[v.mrd] = 0;
    if (set_hit) m_pend[v.ird] = 1;
    if (m_force) begin m_force = 0; m_streak = 0; end
    else if (v.mv && req) begin
      m_streak++;
      if (m_streak == STARVE_LIMIT) begin m_force = 1; m_streak = 0; end
    end else m_streak = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v, col, zero;
    logic mv_r; logic [4:0] mrd_r; logic [31:0] mdata_r;

    zero = row(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 0,0,0,0);
    col  = row(1,3,32'h33, 1,7,32'hbeef, 0,0, 0,0,0, 1,3,32'h33, 0,0,0,0);

    // Reset with live requests: nothing may be granted.
    rst_n = 1'b0;
    v = row(1,5,32'h1234, 1,6,32'h66, 0,0, 4,0,0, 0,0,0, 0,0,0,0);
    drive(v);
    @(negedge clk);
    check("reset.dbg_state", 37'(dbg_state), 37'd0);
    @(posedge clk); #1;
    cycle(v, "reset", 0);
    rst_n = 1'b1;

    tbl.push_back(zero);
    tbl.push_back(row(1,5,32'h1234, 0,0,0, 0,0, 0,0,0, 1,5,32'h1234, 0,0,0,0));
    tbl.push_back(row(1,0,32'hffff, 0,0,0, 0,0, 0,0,0, 0,0,0, 0,0,0,0));
    for (int i = 0; i < 4; i++) tbl.push_back(col);
    tbl.push_back(row(1,3,32'h33, 1,7,32'hbeef, 0,0, 0,0,0, 1,7,32'hbeef, 1,1,0,0));
    tbl.push_back(row(1,3,32'h33, 0,0,0, 0,0, 0,0,0, 1,3,32'h33, 0,0,0,0));
    tbl.push_back(row(0,0,0, 0,0,0, 1,9, 9,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(row(0,0,0, 0,0,0, 0,0, 9,0,0, 0,0,0, 0,0,1,0));
    tbl.push_back(row(0,0,0, 1,9,32'h99, 0,0, 9,0,0, 1,9,32'h99, 1,0,1,0));
    tbl.push_back(row(0,0,0, 0,0,0, 0,0, 9,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(row(0,0,0, 0,0,0, 1,9, 0,9,0, 0,0,0, 0,0,0,0));
    tbl.push_back(row(0,0,0, 1,9,32'haa, 1,9, 0,9,0, 1,9,32'haa, 1,0,1,0));
    tbl.push_back(row(0,0,0, 0,0,0, 0,0, 0,0,9, 0,0,0, 0,0,1,0));
    tbl.push_back(row(0,0,0, 1,9,32'h1, 0,0, 0,0,9, 1,9,32'h1, 1,0,1,0));
    tbl.push_back(row(0,0,0, 0,0,0, 0,0, 0,0,9, 0,0,0, 0,0,0,0));
    tbl.push_back(row(0,0,0, 0,0,0, 1,0, 0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(zero);
    tbl.push_back(row(0,0,0, 1,0,32'h55, 0,0, 0,0,0, 0,0,32'h55, 1,0,0,0));
    // MDU valid drops mid-wait: the starvation count must restart.
    tbl.push_back(col);
    tbl.push_back(col);
    tbl.push_back(row(1,3,32'h33, 0,0,0, 0,0, 0,0,0, 1,3,32'h33, 0,0,0,0));
    for (int i = 0; i < 4; i++) tbl.push_back(col);
    tbl.push_back(row(1,3,32'h33, 1,7,32'hbeef, 0,0, 0,0,0, 1,7,32'hbeef, 1,1,0,0));
    tbl.push_back(row(0,0,0, 0,0,0, 1,4, 0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(row(0,0,0, 0,0,0, 1,4, 0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(row(0,0,0, 0,0,0, 0,0, 4,0,0, 0,0,0, 0,0,1,1));
    tbl.push_back(row(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 0,0,0,1));
    foreach (tbl[i]) cycle(tbl[i], "tbl", i);

    // Reset mid-operation clears pending entries and the sticky error.
    cycle(row(0,0,0, 0,0,0, 1,12, 0,0,0, 0,0,0, 0,0,0,1), "midrst", 0);
    cycle(row(0,0,0, 0,0,0, 0,0, 12,0,0, 0,0,0, 0,0,1,1), "midrst", 1);
    rst_n = 1'b0;
    cycle(row(1,5,32'h5, 1,12,32'hc, 0,0, 12,0,0, 0,0,0, 0,0,0,0), "midrst", 2);
    rst_n = 1'b1;
    cycle(row(0,0,0, 0,0,0, 0,0, 12,0,0, 0,0,0, 0,0,0,0), "midrst", 3);

    // Randomized traffic against the reference model.
    model_reset();
    mv_r = 0; mrd_r = 0; mdata_r = 0;
    for (int n = 0; n < 500; n++) begin
      if (!mv_r && $urandom_range(0, 2) == 0) begin
        mv_r = 1; mrd_r = 5'($urandom_range(0, 7)); mdata_r = $urandom;
      end
      v = zero;
      v.pe = ($urandom_range(0, 3) != 0);
      v.prd = 5'($urandom_range(0, 7));
      v.pdata = $urandom;
      v.mv = mv_r; v.mrd = mrd_r; v.mdata = mdata_r;
      v.ie = ($urandom_range(0, 4) == 0);
      v.ird = 5'($urandom_range(0, 7));
      v.rs1 = 5'($urandom_range(0, 7));
      v.rs2 = 5'($urandom_range(0, 7));
      v.rdd = 5'($urandom_range(0, 7));
      model_step(v);
      cycle(v, "rand", n);
      if (v.e_rdy) mv_r = 0;
    end

    check("exp_q.drained", 37'(exp_q.size()), 37'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
